button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input conditioning front end for the Pomodoro timer. It takes the raw asynchronous push-buttons (tens/units increment and decrement) and the play/pause slide switch, then synchronizes and debounces them. It emits clean one-cycle command pulses, with optional hold-to-auto-repeat, plus a debounced switch level. The countdown core consumes these outputs in place of raw pin levels.

## Interface
Parameters:
- `N_BUTTONS`, 4: number of momentary buttons. Bit order is 0 = bUnidadeAcresce, 1 = bUnidadeDecresce, 2 = bDezenaAcresce, 3 = bDezenaDecresce.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles required before the debounced level changes. Must be ≥ 1.
- `REPEAT_DELAY_CYCLES`, 25000000: hold time from the press pulse to the first repeat pulse. Must be ≥ 1.
- `REPEAT_RATE_CYCLES`, 10000000: spacing between subsequent repeat pulses. Must be ≥ 1.

Ports:
- `clk`, input, 1: the single system clock.
- `rst`, input, 1: reset, **synchronous, active-high**.
- `btn_raw`, input, N_BUTTONS: raw, asynchronous, bouncing button levels; 1 = pressed.
- `sw_raw`, input, 1: raw swPlayPause switch level.
- `btn_pulse`, output, N_BUTTONS: one-cycle command pulse per press or repeat.
- `btn_held`, output, N_BUTTONS: debounced button level.
- `sw_level`, output, 1: debounced switch level.
- `sw_toggle`, output, 1: one-cycle pulse on every debounced switch change.

## Operation
- Every input passes through a 2-flop synchronizer, then a debounce counter.
- Debounce rule:
  - The counter increments while the synchronized value differs from the debounced level.
  - It clears to 0 whenever they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`-1 and the values still differ, the debounced level flips and the counter clears.
  - A bounce shorter than `DEBOUNCE_CYCLES` produces no change.
- Per-button FSM:
  - **IDLE**: when the debounced level rises, assert `btn_pulse` and go to DELAY.
  - **DELAY**: count `REPEAT_DELAY_CYCLES`. At expiry, pulse and go to REPEAT. If the debounced level falls, go to IDLE.
  - **REPEAT**: pulse every `REPEAT_RATE_CYCLES`. If the debounced level falls, go to IDLE.
  - No pulse is ever generated on release.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses, and arbitration belongs to the consumer.
- `sw_toggle` pulses for one cycle on each flip of `sw_level`, in both directions.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- Reset value: all outputs 0. Synchronizer flops, debounced levels and counters are 0, and every FSM is in IDLE.
- Reset takes effect on the first `clk` edge with `rst`=1 and aborts any operation in progress.
- An input held high through reset is treated as a new press and pulses after the full latency.
- Latency: if `btn_raw` rises before edge k and stays stable, `btn_held` and `btn_pulse` are high in the cycle after edge k+1+`DEBOUNCE_CYCLES`. Total: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
- All outputs are registered, with no combinational path from inputs to outputs.
- `btn_pulse` is exactly 1 cycle wide.
- First repeat: `REPEAT_DELAY_CYCLES` cycles after the press pulse, measured pulse-to-pulse.
- Later repeats: every `REPEAT_RATE_CYCLES` cycles.
- Release during the cycle a repeat is due: the release wins and no pulse is emitted.
- `sw_level` and `sw_toggle` follow the same latency as the buttons.

## Configuration
- **`BUTTON_AUTOREPEAT_EN`** defined:
  - The DELAY and REPEAT states and their counters are compiled in, and behaviour is as described above.
  - The parameters `REPEAT_DELAY_CYCLES` and `REPEAT_RATE_CYCLES` are used.
- Undefined:
  - The FSM reduces to IDLE and HELD, with exactly one `btn_pulse` per debounced press.
  - `REPEAT_DELAY_CYCLES` and `REPEAT_RATE_CYCLES` are ignored and no repeat counters are synthesized.

## Structure
- `pomodoro_pkg`: holds the button FSM state enum (IDLE, DELAY, REPEAT, HELD), the default cycle constants, and the named button-index constants.
- Sub-module `button_channel`: one synchronizer + debouncer + FSM per input, with parameters forwarded.
  - The top instantiates `N_BUTTONS`+1 copies via generate.
  - The switch channel uses only the debounced level and its change pulse, with its repeat logic left unused.

## Test plan
Use bench parameters `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_CYCLES`=20, `REPEAT_RATE_CYCLES`=5.
1. **Reset**: assert `rst` for 2 cycles with all inputs high → all outputs 0 during reset. After release, `btn_pulse`=4'b1111 exactly once, 6 cycles after `rst` falls.
2. **Bounce rejection**: toggle `btn_raw[0]` 1/0 with periods of 3 cycles for 30 cycles, then hold 0 → `btn_pulse[0]` is never asserted.
3. **Clean press**: `btn_raw[2]` held high for 10 cycles → a single 1-cycle `btn_pulse[2]` 6 cycles after the rise, and no pulse on release.
4. **Auto-repeat** (macro defined): hold `btn_raw[1]` for 60 cycles → pulses at offsets 0, 20, 25, 30, 35, … from the first pulse. With the macro undefined → a single pulse only.
5. **Simultaneous**: `btn_raw[0]` and `btn_raw[3]` rise on the same cycle → both bits of `btn_pulse` are high on the same cycle.
6. **Switch**: `sw_raw` goes 0→1→0 with 10 cycles high → `sw_level` high for 10 cycles, and `sw_toggle` pulses at both edges.

Source files
------------

// File: rtl/pomodoro_pkg.sv
`default_nettype none
// ============================================================================
// pomodoro_pkg : shared button FSM states, default timings, button indices
// Rev 1.0
// ============================================================================
package pomodoro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } btn_state_e;

  localparam int c_DEFAULT_N_BUTTONS           = 4;
  localparam int c_DEFAULT_DEBOUNCE_CYCLES     = 500000;
  localparam int c_DEFAULT_REPEAT_DELAY_CYCLES = 25000000;
  localparam int c_DEFAULT_REPEAT_RATE_CYCLES  = 10000000;

  localparam int c_BTN_UNIT_INC = 0;
  localparam int c_BTN_UNIT_DEC = 1;
  localparam int c_BTN_TENS_INC = 2;
  localparam int c_BTN_TENS_DEC = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// button_channel : 2-flop sync + debouncer + press/repeat FSM for one input.
// BUTTON_AUTOREPEAT_EN adds DELAY/REPEAT states; otherwise IDLE/HELD only.
// Rev 1.0
// ============================================================================
module button_channel
  import pomodoro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = c_DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = c_DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = c_DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic toggle_o
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [c_DB_W-1:0] db_cnt_q, db_cnt_d;
  logic              pulse_q, pulse_d;
  logic              toggle_q;
  logic              w_rise;
  btn_state_e        state_q, state_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q >= c_DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + c_DB_W'(1);
      end
    end
  end

  // Press is detected on the same edge the debounced level flips, so the
  // pulse and the held level appear together.
  assign w_rise = level_d & ~level_q;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int c_RPT_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
  localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_RATE_LAST  = c_RPT_W'(REPEAT_RATE_CYCLES - 1);

  logic [c_RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          pulse_d   = 1'b1;
          state_d   = ST_DELAY;
          rpt_cnt_d = '0;
        end
      end
      ST_DELAY: begin
        // A release on the due cycle suppresses that repeat.
        if (!level_d) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q >= c_DELAY_LAST) begin
          pulse_d   = 1'b1;
          state_d   = ST_REPEAT;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q != '1) begin
          rpt_cnt_d = rpt_cnt_q + c_RPT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!level_d) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q >= c_RATE_LAST) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q != '1) begin
          rpt_cnt_d = rpt_cnt_q + c_RPT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  localparam int c_unused_repeat_cfg = REPEAT_DELAY_CYCLES + REPEAT_RATE_CYCLES;

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          pulse_d = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!level_d) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      toggle_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      pulse_q  <= pulse_d;
      toggle_q <= level_d ^ level_q;
      state_q  <= state_d;
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign toggle_o = toggle_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner : debounced command pulses for N buttons + play/pause
// switch level/toggle. Auto-repeat enabled by BUTTON_AUTOREPEAT_EN.
// Rev 1.0
// ============================================================================
module button_conditioner
  import pomodoro_pkg::*;
#(
  parameter int N_BUTTONS           = c_DEFAULT_N_BUTTONS,
  parameter int DEBOUNCE_CYCLES     = c_DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = c_DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = c_DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic                 sw_raw,
  output logic [N_BUTTONS-1:0] btn_pulse,
  output logic [N_BUTTONS-1:0] btn_held,
  output logic                 sw_level,
  output logic                 sw_toggle
);

  // Channel N_BUTTONS is the switch; the rest are buttons in index order.
  logic [N_BUTTONS:0] w_raw;
  logic [N_BUTTONS:0] w_level;
  logic [N_BUTTONS:0] w_pulse;
  logic [N_BUTTONS:0] w_toggle;
  logic               w_unused_bits;

  assign w_raw = {sw_raw, btn_raw};

  for (genvar g = 0; g <= N_BUTTONS; g++) begin : g_channel
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (w_raw[g]),
      .level_o (w_level[g]),
      .pulse_o (w_pulse[g]),
      .toggle_o(w_toggle[g])
    );
  end

  assign btn_pulse     = w_pulse[N_BUTTONS-1:0];
  assign btn_held      = w_level[N_BUTTONS-1:0];
  assign sw_level      = w_level[N_BUTTONS];
  assign sw_toggle     = w_toggle[N_BUTTONS];
  assign w_unused_bits = ^{w_pulse[N_BUTTONS], w_toggle[N_BUTTONS-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// tb_button_conditioner : directed self-checking bench for button_conditioner
// Rev 1.0
// ============================================================================
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       sw_raw;
  logic [3:0] btn_pulse;
  logic [3:0] btn_held;
  logic       sw_level;
  logic       sw_toggle;

  int n_cmp  = 0;
  int n_fail = 0;

  button_conditioner #(
    .N_BUTTONS          (4),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_pulse(btn_pulse),
    .btn_held (btn_held),
    .sw_level (sw_level),
    .sw_toggle(sw_toggle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold of btn_raw[1] from tick 1 to 60: press pulse at 6, repeats at
  // 26 then every 5; the repeat due at 66 collides with the release.
  function automatic logic exp_rep(input int i);
`ifdef BUTTON_AUTOREPEAT_EN
    if (i == 6) return 1'b1;
    if (i >= 26 && i <= 61 && ((i - 26) % 5) == 0) return 1'b1;
    return 1'b0;
`else
    return (i == 6);
`endif
  endfunction

  initial begin
    // 1: reset with all inputs high
    rst     = 1'b1;
    btn_raw = 4'hF;
    sw_raw  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_pulse%0d", i), 32'(btn_pulse), 32'h0);
      check($sformatf("rst_held%0d", i), 32'(btn_held), 32'h0);
      check($sformatf("rst_sw%0d", i), {30'h0, sw_level, sw_toggle}, 32'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("post_rst_pulse_t%0d", i), 32'(btn_pulse), (i == 6) ? 32'hF : 32'h0);
      check($sformatf("post_rst_held_t%0d", i), 32'(btn_held), (i >= 6) ? 32'hF : 32'h0);
      check($sformatf("post_rst_sw_t%0d", i), {30'h0, sw_level, sw_toggle},
            (i == 6) ? 32'h3 : ((i > 6) ? 32'h2 : 32'h0));
    end
    btn_raw = 4'h0;
    sw_raw  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("rel_all_pulse_t%0d", i), 32'(btn_pulse), 32'h0);
      check($sformatf("rel_all_held_t%0d", i), 32'(btn_held), (i < 6) ? 32'hF : 32'h0);
    end

    // 2: bounce shorter than the debounce window
    for (int i = 1; i <= 30; i++) begin
      btn_raw[0] = (((i - 1) / 3) % 2) == 0;
      tick();
      check($sformatf("bounce_pulse_t%0d", i), 32'(btn_pulse[0]), 32'h0);
      check($sformatf("bounce_held_t%0d", i), 32'(btn_held[0]), 32'h0);
    end
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("bounce_tail_t%0d", i), 32'(btn_pulse), 32'h0);
    end

    // 3: clean press of button 2 for 10 cycles
    btn_raw[2] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("clean_pulse_t%0d", i), 32'(btn_pulse), (i == 6) ? 32'h4 : 32'h0);
      check($sformatf("clean_held_t%0d", i), 32'(btn_held),
            (i >= 6 && i <= 15) ? 32'h4 : 32'h0);
      if (i == 10) btn_raw[2] = 1'b0;
    end

    // 4: long hold of button 1
    btn_raw[1] = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      tick();
      check($sformatf("repeat_pulse_t%0d", i), 32'(btn_pulse), {30'h0, exp_rep(i), 1'b0});
      if (i == 60) btn_raw[1] = 1'b0;
    end

    // 5: simultaneous press of buttons 0 and 3
    btn_raw = 4'b1001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("simul_pulse_t%0d", i), 32'(btn_pulse), (i == 6) ? 32'h9 : 32'h0);
    end
    btn_raw = 4'h0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("simul_rel_t%0d", i), 32'(btn_pulse), 32'h0);
    end

    // 6: switch high for 10 cycles
    sw_raw = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      check($sformatf("sw_level_t%0d", i), 32'(sw_level), (i >= 6 && i <= 15) ? 32'h1 : 32'h0);
      check($sformatf("sw_toggle_t%0d", i), 32'(sw_toggle), (i == 6 || i == 16) ? 32'h1 : 32'h0);
      check($sformatf("sw_btn_quiet_t%0d", i), 32'(btn_pulse), 32'h0);
      if (i == 10) sw_raw = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
